mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer between the CPU core and the 256×8 synchronous `ram` block, which has one-cycle registered read latency. It accepts one byte or 16-bit word request per handshake from the core. Each request becomes one or two byte-wide RAM strobes, and read bytes are captured on the cycle they become valid. Words are little-endian: the low byte is at `addr` and the high byte at `addr+1`, with the address wrapping mod 256.

## Interface
Parameters:
- none; the 8-bit address and 256-byte space are fixed.

Ports:
- `clk`  in  1  single clock; all registers update on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  core request; sampled only while `ready`=1.
- `wr`  in  1  1 = store, 0 = load.
- `size`  in  1  0 = byte, 1 = 16-bit word.
- `addr`  in  8  byte address of the low byte.
- `wdata`  in  16  store data; byte store uses `[7:0]`.
- `ready`  out  1  unit idle, able to accept a request.
- `done`  out  1  one-cycle pulse when the request completes.
- `rdata`  out  16  load result; byte load is zero-extended.
- `ram_addr`  out  8  to `ram.addr`.
- `ram_we`  out  1  to `ram.we`.
- `ram_re`  out  1  to `ram.re`.
- `ram_wdata`  out  8  to `ram.data_in`.
- `ram_rdata`  in  8  from `ram.data_out`.

## Operation
- All outputs are registered.
- Reset values: `ready`=1, `done`=0, `rdata`=0x0000, `ram_addr`=0x00, `ram_we`=0, `ram_re`=0, `ram_wdata`=0x00. The state register resets to IDLE.
- Reset asserted mid-operation: outputs and state go to their reset values immediately (asynchronously). The in-flight request is abandoned with no `done` pulse.
- States:
  - **IDLE**
    - `ready`=1.
    - On `req`=1 at a posedge: latch `wr`, `size`, `addr`, `wdata`.
    - Drive `ram_addr`=`addr`.
    - For a store, drive `ram_we`=1 and `ram_wdata`=`wdata[7:0]`; for a load, drive `ram_re`=1.
    - Clear `ready` and go to LO.
  - **LO**
    - The low-byte strobe is active this cycle.
    - If word: drive `ram_addr`=`addr+1` (8-bit wrap, 0xFF→0x00) and the same strobe type. For a store, `ram_wdata`=`wdata[15:8]`. Go to HI.
    - If byte: strobes to 0, go to FIN.
  - **HI**
    - The high-byte strobe is active this cycle.
    - If load, capture `ram_rdata` into `rdata[7:0]`.
    - Strobes to 0, go to FIN.
  - **FIN**
    - If byte load: `rdata`={0x00, `ram_rdata`}.
    - If word load: capture `ram_rdata` into `rdata[15:8]`.
    - Set `done`=1 and `ready`=1, go to IDLE.
- `done` clears after one cycle.
- `rdata` holds its value until the next load completes. Stores never modify `rdata`.
- `ram_we` and `ram_re` are never both 1 and are never 1 in IDLE or FIN.
- `req` while `ready`=0 is ignored (no queuing); the core holds `req` until accepted.
- Inputs changing after acceptance have no effect.
- `ram_addr` and `ram_wdata` hold their last values when the strobes are low.

## Timing
- Acceptance edge = E0.
- Byte access: LO during E0–E1, FIN during E1–E2. `done`=1 and valid `rdata` in the cycle after E2, i.e. 3 edges from acceptance.
- Word access: LO, HI, FIN, then `done` in the cycle after E3 (4 edges).
- Throughput: a new `req` may be accepted in the same cycle `done`=1, since `ready`=1 in that cycle. Back-to-back byte requests run at 1 per 3 cycles.
- RAM read latency is fixed at 1 cycle: data for a strobe in cycle N is on `ram_rdata` in cycle N+1 and is captured at that cycle's closing edge.

## Test plan
- **Reset:** pulse `rst` mid-cycle, then release.
  - Required: `ready`=1, `done`=0, `rdata`=0x0000, `ram_we`=`ram_re`=0, asserted asynchronously.
- **Byte store/load:** byte store 0x5A @0x10, then byte load @0x10.
  - Required: `ram_we` high exactly 1 cycle with `ram_addr`=0x10.
  - Required: the load's `done` pulse arrives 3 edges after acceptance with `rdata`=0x005A.
- **Word store/load:** word store 0xBEEF @0x20, then word load @0x20.
  - Required: RAM[0x20]=0xEF and RAM[0x21]=0xBE.
  - Required: `done` 4 edges after acceptance with `rdata`=0xBEEF.
- **Address wrap:** word store 0x1234 @0xFF.
  - Required: RAM[0xFF]=0x34 and RAM[0x00]=0x12; a word load @0xFF returns 0x1234.
- **Handshake:** toggle `req` with different `addr` while `ready`=0, then issue a new request in the `done` cycle.
  - Required: no extra strobes from the busy-period toggles.
  - Required: the second request is accepted in the `done` cycle and completes correctly.
- **Reset mid-word:** word store 0xAAAA @0x40 (RAM pre-loaded 0x00), with `rst` asserted during HI before its closing edge.
  - Required: strobes drop immediately, RAM[0x40]=0xAA, RAM[0x41]=0x00, no `done`, `ready`=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the core and a 256x8 RAM with 1-cycle registered read.
// Latency: byte access done 3 edges after acceptance, word access 4 edges.
// Backpressure: ready low while busy; req is ignored (not queued) until ready returns.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic        size,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [15:0] rdata,
    output logic [7:0]  ram_addr,
    output logic        ram_we,
    output logic        ram_re,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    // IDLE: waiting; LO: low-byte strobe on the bus; HI: high-byte strobe on
    // the bus; FIN: last read byte arriving, request retires.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t      state, state_nxt;

    // Request fields frozen at acceptance so later input changes are ignored.
    logic        op_wr, op_wr_nxt;
    logic        op_size, op_size_nxt;
    logic [7:0]  op_addr, op_addr_nxt;
    logic [15:0] op_wdata, op_wdata_nxt;

    logic        ready_nxt;
    logic        done_nxt;
    logic [15:0] rdata_nxt;
    logic [7:0]  ram_addr_nxt;
    logic        ram_we_nxt;
    logic        ram_re_nxt;
    logic [7:0]  ram_wdata_nxt;

    // High-byte address wraps naturally in 8 bits (0xFF -> 0x00).
    logic [7:0]  op_addr_hi;
    assign op_addr_hi = op_addr + 8'd1;

    // State register plus every registered output; reset abandons any request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            op_size   <= 1'b0;
            op_addr   <= 8'h00;
            op_wdata  <= 16'h0000;
            ready     <= 1'b1;
            done      <= 1'b0;
            rdata     <= 16'h0000;
            ram_addr  <= 8'h00;
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            ram_wdata <= 8'h00;
        end else begin
            state     <= state_nxt;
            op_wr     <= op_wr_nxt;
            op_size   <= op_size_nxt;
            op_addr   <= op_addr_nxt;
            op_wdata  <= op_wdata_nxt;
            ready     <= ready_nxt;
            done      <= done_nxt;
            rdata     <= rdata_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_we    <= ram_we_nxt;
            ram_re    <= ram_re_nxt;
            ram_wdata <= ram_wdata_nxt;
        end
    end

    // Next-state and next-output decode; strobes default low, address/data hold.
    always_comb begin
        state_nxt     = state;
        op_wr_nxt     = op_wr;
        op_size_nxt   = op_size;
        op_addr_nxt   = op_addr;
        op_wdata_nxt  = op_wdata;
        ready_nxt     = ready;
        done_nxt      = 1'b0;
        rdata_nxt     = rdata;
        ram_addr_nxt  = ram_addr;
        ram_we_nxt    = 1'b0;
        ram_re_nxt    = 1'b0;
        ram_wdata_nxt = ram_wdata;

        unique case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (req) begin
                    op_wr_nxt    = wr;
                    op_size_nxt  = size;
                    op_addr_nxt  = addr;
                    op_wdata_nxt = wdata;
                    ram_addr_nxt = addr;
                    if (wr) begin
                        ram_we_nxt    = 1'b1;
                        ram_wdata_nxt = wdata[7:0];
                    end else begin
                        ram_re_nxt    = 1'b1;
                    end
                    ready_nxt = 1'b0;
                    state_nxt = LO;
                end
            end

            LO: begin
                if (op_size) begin
                    ram_addr_nxt = op_addr_hi;
                    if (op_wr) begin
                        ram_we_nxt    = 1'b1;
                        ram_wdata_nxt = op_wdata[15:8];
                    end else begin
                        ram_re_nxt    = 1'b1;
                    end
                    state_nxt = HI;
                end else begin
                    state_nxt = FIN;
                end
            end

            HI: begin
                // Low byte of a word load is on ram_rdata this cycle.
                if (!op_wr) begin
                    rdata_nxt[7:0] = ram_rdata;
                end
                state_nxt = FIN;
            end

            FIN: begin
                // Final read byte is on ram_rdata this cycle.
                if (!op_wr) begin
                    if (op_size) begin
                        rdata_nxt[15:8] = ram_rdata;
                    end else begin
                        rdata_nxt = {8'h00, ram_rdata};
                    end
                end
                done_nxt  = 1'b1;
                ready_nxt = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic        size;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        ready;
    logic        done;
    logic [15:0] rdata;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic        ram_re;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    mem_access_unit dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .done      (done),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 256x8 RAM with one-cycle registered read.
    logic [7:0] ram_mem [256] = '{default: 8'h00};
    initial ram_rdata = 8'h00;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference memory contents as the core should see them.
    logic [7:0] model_mem [256] = '{default: 8'h00};

    typedef struct {
        logic [7:0] a;
        logic       we;
        logic [7:0] d;
    } strb_t;

    typedef struct {
        logic        is_load;
        logic [15:0] exp;
        int          acc;
        int          lat;
    } done_t;

    strb_t       sq[$];
    done_t       dq[$];
    logic [15:0] hold = 16'h0000;

    int checks = 0;
    int errs   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void flag(input string name);
        checks++;
        errs++;
        $display("FAIL %s (t=%0t)", name, $time);
    endfunction

    // Pops expected strobes / completions whenever the DUT presents them.
    task automatic monitor();
        strb_t se;
        done_t de;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 16'h0000;
            end else begin
                if (ram_we || ram_re) begin
                    chk("strobe_exclusive", 32'(ram_we & ram_re), 32'd0);
                    if (sq.size() == 0) begin
                        flag($sformatf("unexpected_strobe addr=0x%0h we=%0b re=%0b", ram_addr, ram_we, ram_re));
                    end else begin
                        se = sq.pop_front();
                        chk("strobe_addr", 32'(ram_addr), 32'(se.a));
                        chk("strobe_we", 32'(ram_we), 32'(se.we));
                        if (se.we) chk("strobe_wdata", 32'(ram_wdata), 32'(se.d));
                    end
                end
                if (done) begin
                    if (dq.size() == 0) begin
                        flag("unexpected_done");
                    end else begin
                        de = dq.pop_front();
                        chk("done_latency", 32'(cyc - de.acc), 32'(de.lat));
                        if (de.is_load) hold = de.exp;
                        chk("rdata", 32'(rdata), 32'(hold));
                        chk("ready_with_done", 32'(ready), 32'd1);
                    end
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic issue(input logic w, input logic s, input logic [7:0] a,
                         input logic [15:0] d, output logic acc_done);
        int          waitc;
        logic [7:0]  a1;
        done_t       de;
        acc_done = 1'b0;
        a1 = a + 8'd1;
        req = 1'b1; wr = w; size = s; addr = a; wdata = d;
        waitc = 0;
        while (!ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!ready) begin
            flag("accept_timeout");
            req = 1'b0;
            return;
        end
        acc_done = done;
        sq.push_back('{a, w, d[7:0]});
        if (s) sq.push_back('{a1, w, d[15:8]});
        de.is_load = !w;
        de.exp     = s ? {model_mem[a1], model_mem[a]} : {8'h00, model_mem[a]};
        de.acc     = cyc;
        de.lat     = s ? 4 : 3;
        dq.push_back(de);
        if (w) begin
            model_mem[a] = d[7:0];
            if (s) model_mem[a1] = d[15:8];
        end
        @(posedge clk);
        @(negedge clk);
        waitc = 0;
        // Junk on the request lines while busy must be ignored.
        while (!ready && waitc < 50) begin
            req   = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            size  = 1'($urandom_range(0, 1));
            addr  = 8'($urandom);
            wdata = 16'($urandom);
            @(negedge clk);
            waitc++;
        end
        if (!ready) flag("done_timeout");
        req = 1'b0;
    endtask

    logic ad;

    initial begin
        rst = 1'b0; req = 1'b0; wr = 1'b0; size = 1'b0; addr = 8'h00; wdata = 16'h0000;
        fork
            monitor();
        join_none

        // Asynchronous reset mid-cycle.
        #3 rst = 1'b1;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);
        chk("rst_re", 32'(ram_re), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Byte store/load.
        issue(1'b1, 1'b0, 8'h10, 16'h005A, ad);
        issue(1'b0, 1'b0, 8'h10, 16'h0000, ad);
        chk("byte_load_value", 32'(rdata), 32'h005A);

        // Word store/load.
        issue(1'b1, 1'b1, 8'h20, 16'hBEEF, ad);
        chk("ram_20", 32'(ram_mem[8'h20]), 32'hEF);
        chk("ram_21", 32'(ram_mem[8'h21]), 32'hBE);
        issue(1'b0, 1'b1, 8'h20, 16'h0000, ad);
        chk("word_load_value", 32'(rdata), 32'hBEEF);

        // Address wrap.
        issue(1'b1, 1'b1, 8'hFF, 16'h1234, ad);
        chk("ram_ff", 32'(ram_mem[8'hFF]), 32'h34);
        chk("ram_00", 32'(ram_mem[8'h00]), 32'h12);
        issue(1'b0, 1'b1, 8'hFF, 16'h0000, ad);
        chk("wrap_load_value", 32'(rdata), 32'h1234);

        // Handshake: busy-period toggles plus acceptance in the done cycle.
        issue(1'b1, 1'b0, 8'h50, 16'h77C3, ad);
        issue(1'b0, 1'b0, 8'h50, 16'h0000, ad);
        chk("accept_in_done_cycle", 32'(ad), 32'd1);
        chk("handshake_load_value", 32'(rdata), 32'h00C3);

        // Randomized traffic in a region not used by the directed checks.
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(8'h80, 8'hF0)), 16'($urandom), ad);
        end

        // Reset during the HI cycle of a word store.
        issue(1'b1, 1'b1, 8'h40, 16'h0000, ad);
        issue(1'b0, 1'b1, 8'h20, 16'h0000, ad);
        chk("pre_reset_ready", 32'(ready), 32'd1);
        req = 1'b1; wr = 1'b1; size = 1'b1; addr = 8'h40; wdata = 16'hAAAA;
        sq.push_back('{8'h40, 1'b1, 8'hAA});
        model_mem[8'h40] = 8'hAA;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_we", 32'(ram_we), 32'd0);
        chk("midrst_re", 32'(ram_re), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_ram_40", 32'(ram_mem[8'h40]), 32'hAA);
        chk("midrst_ram_41", 32'(ram_mem[8'h41]), 32'h00);
        issue(1'b0, 1'b1, 8'h40, 16'h0000, ad);
        chk("post_reset_load", 32'(rdata), 32'h00AA);

        repeat (3) @(negedge clk);
        chk("strobe_queue_empty", 32'(sq.size()), 32'd0);
        chk("done_queue_empty", 32'(dq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end

endmodule
